// File: rtl/mcs_brg_pkg.sv
// Shared types and constants for the wait-state MCS-to-FPro bridge.
// Timeout logic is compiled in only when MCS_BRG_TIMEOUT_EN is defined.
package mcs_brg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } brg_state_t;

    localparam logic [31:0] BRG_ERR_DATA = 32'hDEAD_BEEF;
    localparam int          BRG_PAGE_MSB = 31;
    localparam int          BRG_PAGE_LSB = 24;

    // Region index width; a single region still needs one index bit.
    function automatic int rg_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mcs_brg_timeout.sv
// Access watchdog: counts stalled ACCESS cycles, flags expiry and keeps a
// saturating count of expired accesses. Used only under MCS_BRG_TIMEOUT_EN.
module mcs_brg_timeout #(
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    output logic       expire,
    output logic [7:0] err_cnt
);

    logic [15:0] to_cnt_q, to_cnt_d;
    logic [7:0]  err_cnt_q, err_cnt_d;

    always_comb begin
        expire    = en && (to_cnt_q == 16'(TIMEOUT - 1));
        to_cnt_d  = to_cnt_q;
        err_cnt_d = err_cnt_q;
        if (clr) begin
            to_cnt_d = '0;
        end else if (en) begin
            to_cnt_d = to_cnt_q + 16'd1;
        end
        if (expire && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;

endmodule

// File: rtl/mcs_bridge_ws.sv
// MCS IO bus to FPro bus bridge with per-region chip selects and wait states.
// Define MCS_BRG_TIMEOUT_EN to force completion of accesses that never get ready.
module mcs_bridge_ws
    import mcs_brg_pkg::*;
#(
    parameter logic [31:0] BRG_BASE = 32'hC000_0000,
    parameter int          N_REGION = 2,
    parameter int          ADDR_W   = 21,
    parameter int          TIMEOUT  = 255
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   io_addr_strobe,
    input  logic                   io_read_strobe,
    input  logic                   io_write_strobe,
    input  logic [3:0]             io_byte_enable,
    input  logic [31:0]            io_address,
    input  logic [31:0]            io_write_data,
    output logic [31:0]            io_read_data,
    output logic                   io_ready,
    output logic [N_REGION-1:0]    fp_cs,
    output logic                   fp_wr,
    output logic                   fp_rd,
    output logic [ADDR_W-1:0]      fp_addr,
    output logic [3:0]             fp_be,
    output logic [31:0]            fp_wr_data,
    input  logic [32*N_REGION-1:0] fp_rd_data,
    input  logic [N_REGION-1:0]    fp_ready,
    output logic [7:0]             err_cnt,
    output brg_state_t             dbg_state
);

    localparam int RG_W = rg_width(N_REGION);

    brg_state_t          state_q, state_d;
    logic [RG_W-1:0]     rg_q, rg_d;
    logic [N_REGION-1:0] cs_q, cs_d;
    logic                rd_q, rd_d, wr_q, wr_d, ready_q, ready_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [3:0]          be_q, be_d;
    logic [31:0]         wdata_q, wdata_d, rdata_q, rdata_d;

    logic [RG_W-1:0] rg_in;
    logic            hit, sel_ready, expire, to_clr;

    assign rg_in     = io_address[23 -: RG_W];
    assign hit       = (io_address[BRG_PAGE_MSB:BRG_PAGE_LSB] == BRG_BASE[BRG_PAGE_MSB:BRG_PAGE_LSB])
                       && (int'(rg_in) < N_REGION);
    assign sel_ready = fp_ready[rg_q];

    always_comb begin
        state_d = state_q;
        rg_d    = rg_q;
        cs_d    = cs_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ready_d = 1'b0;
        to_clr  = 1'b0;
        case (state_q)
            IDLE: begin
                if (io_addr_strobe) begin
                    addr_d  = io_address[ADDR_W+1:2];
                    be_d    = io_byte_enable;
                    wdata_d = io_write_data;
                    if (hit) begin
                        state_d     = ACCESS;
                        rg_d        = rg_in;
                        to_clr      = 1'b1;
                        cs_d        = '0;
                        cs_d[rg_in] = 1'b1;
                        wr_d        = io_write_strobe;
                        rd_d        = io_read_strobe && !io_write_strobe;
                    end else begin
                        // Unmapped page: answer immediately with zero data.
                        state_d = RESP;
                        ready_d = 1'b1;
                        rdata_d = '0;
                    end
                end
            end
            ACCESS: begin
                if (sel_ready || expire) begin
                    state_d = RESP;
                    ready_d = 1'b1;
                    cs_d    = '0;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    if (!sel_ready) begin
                        rdata_d = BRG_ERR_DATA;
                    end else if (rd_q) begin
                        rdata_d = fp_rd_data[32*int'(rg_q) +: 32];
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            rg_q    <= '0;
            cs_q    <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rg_q    <= rg_d;
            cs_q    <= cs_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
        end
    end

`ifdef MCS_BRG_TIMEOUT_EN
    mcs_brg_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .rst_n   (reset_n),
        .clr     (to_clr),
        .en      ((state_q == ACCESS) && !sel_ready),
        .expire  (expire),
        .err_cnt (err_cnt)
    );
`else
    localparam int unused_timeout = TIMEOUT;
    logic unused_to_clr;
    assign unused_to_clr = to_clr;
    assign expire        = 1'b0;
    assign err_cnt       = '0;
`endif

    logic unused_addr_lsb;
    assign unused_addr_lsb = ^io_address[1:0];

    assign io_read_data = rdata_q;
    assign io_ready     = ready_q;
    assign fp_cs        = cs_q;
    assign fp_rd        = rd_q;
    assign fp_wr        = wr_q;
    assign fp_addr      = addr_q;
    assign fp_be        = be_q;
    assign fp_wr_data   = wdata_q;
    assign dbg_state    = state_q;

endmodule
